bcd_serial_adder: RTL and testbench

- Parametrised N-digit BCD adder/subtractor; successor to the two-digit combinational BCD adder.
- Processes one BCD digit per clock, least significant digit first, under a start/done handshake.
- Detects invalid (>9) operand digits and supports ten's-complement subtraction.
- Sits between board switch/register inputs and the per-digit seven-segment decoders. An all-ones error digit (4'hF) blanks a display digit, because the decoders treat values above 9 as blank.

---
 rtl/bcd_serial_adder.sv | 206 ++++++++++++++++++++
 tb/tb_bcd_serial_adder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder/subtractor, LSD first, start/done handshake.
// Ten's-complement subtract, invalid-digit detection, blanking error result.
//
// Ports:
//   CLOCK_50 : system clock, rising edge
//   KEY0     : synchronous active-low reset
//   start    : request, sampled in IDLE or DONE
//   sub      : 0 = A+B+cin, 1 = A-B (ten's complement)
//   cin      : carry-in for add mode, ignored when subtracting
//   a_bcd    : operand A, digit i at [4i+3:4i]
//   b_bcd    : operand B, same packing
//   busy     : high while digits are being processed
//   done     : one-cycle pulse when results update
//   sum_bcd  : registered result digits
//   cout     : final decimal carry (sub: 1 = non-negative)
//   err      : an operand digit above 9 was seen in the last operation

module bcd_serial_adder #(
   parameter int  DIGITS = 4,
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  CLOCK_50,
   input  logic                  KEY0,
   input  logic                  start,
   input  logic                  sub,
   input  logic                  cin,
   input  logic [4*DIGITS-1:0]   a_bcd,
   input  logic [4*DIGITS-1:0]   b_bcd,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum_bcd,
   output logic                  cout,
   output logic                  err
);

   localparam int               W    = 4 * DIGITS;
   localparam logic [CW-1:0]    LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;

   // Operands shift right one digit per ADD cycle, so the digit
   // being worked on is always in the low nibble.
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            sub_q, sub_d;
   logic            carry_q, carry_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic            eflag_q, eflag_d;

   // Result digits enter at the top and shift down; after DIGITS
   // steps digit 0 sits in the low nibble.
   logic [W-1:0]    acc_q, acc_d;

   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            err_q, err_d;
   logic            done_q, done_d;

   logic            cap;

   // ---------------------------------------------------------------
   // Single-digit BCD cell
   // ---------------------------------------------------------------
   logic [3:0]      a_dig;
   logic [3:0]      b_dig;
   logic [3:0]      bd;
   logic [4:0]      s;
   logic            gt9;
   logic [3:0]      dig;
   logic            bad;
   logic [W+3:0]    acc_ext;

   always_comb begin
      a_dig = a_q[3:0];
      b_dig = b_q[3:0];
      // Nine's complement of B; the +1 of ten's complement arrives
      // as the initial carry.
      bd    = sub_q ? (4'd9 - b_dig) : b_dig;
      s     = {1'b0, a_dig} + {1'b0, bd} + {4'b0000, carry_q};
      gt9   = (s > 5'd9);
      // Modulo-16 subtract yields the correct low nibble of s-10.
      dig   = gt9 ? (s[3:0] - 4'd10) : s[3:0];
      // Range check on raw B, before any complement.
      bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
      acc_ext = {dig, acc_q};
   end

   // ---------------------------------------------------------------
   // Next-state and datapath control
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      eflag_d = eflag_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      err_d   = err_q;
      done_d  = 1'b0;
      cap     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cap = 1'b1;
            end
         end

         S_ADD: begin
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            carry_d = gt9;
            acc_d   = acc_ext[W+3:4];
            idx_d   = idx_q + CW'(1);
            if (bad) begin
               eflag_d = 1'b1;
            end
            if (idx_q == LAST) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            done_d = 1'b1;
            err_d  = eflag_q;
            if (eflag_q) begin
               sum_d  = '1;
               cout_d = 1'b0;
            end else begin
               sum_d  = acc_q;
               cout_d = carry_q;
            end
            if (start) begin
               cap = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (cap) begin
         a_d     = a_bcd;
         b_d     = b_bcd;
         sub_d   = sub;
         carry_d = sub | cin;
         idx_d   = '0;
         eflag_d = 1'b0;
         acc_d   = '0;
         state_d = S_ADD;
      end
   end

   // ---------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         eflag_q <= 1'b0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         eflag_q <= eflag_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign busy    = (state_q == S_ADD);
   assign done    = done_q;
   assign sum_bcd = sum_q;
   assign cout    = cout_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: integer-arithmetic reference model,
// per-cycle compare, directed literal cases and random traffic.

module tb_bcd_serial_adder;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic          clk;
   logic          KEY0;
   logic          start;
   logic          sub;
   logic          cin;
   logic [W-1:0]  a_bcd;
   logic [W-1:0]  b_bcd;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum_bcd;
   logic          cout;
   logic          err;

   int checks;
   int fails;
   bit chk_en;

   bcd_serial_adder #(.DIGITS(D)) dut (
      .CLOCK_50 (clk),
      .KEY0     (KEY0),
      .start    (start),
      .sub      (sub),
      .cin      (cin),
      .a_bcd    (a_bcd),
      .b_bcd    (b_bcd),
      .busy     (busy),
      .done     (done),
      .sum_bcd  (sum_bcd),
      .cout     (cout),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // ---------------- BCD <-> integer ----------------
   function automatic bit bcd_ok(input logic [W-1:0] v);
      for (int i = 0; i < D; i++)
         if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic longint bcd2int(input logic [W-1:0] v);
      longint r = 0;
      for (int i = D - 1; i >= 0; i--)
         r = r * 10 + longint'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input longint n);
      logic [W-1:0] r = '0;
      longint       t = n;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
      logic [W-1:0] r;
      for (int i = 0; i < D; i++) begin
         if (allow_bad && ($urandom_range(0, 19) == 0))
            r[4*i +: 4] = 4'($urandom_range(10, 15));
         else
            r[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return r;
   endfunction

   // ---------------- reference model ----------------
   longint        MOD;
   logic [W-1:0]  exp_sum;
   logic          exp_cout;
   logic          exp_err;
   logic          exp_busy;
   logic          exp_done;
   int            remaining;
   bit            finishing;
   logic [W-1:0]  pend_sum;
   logic          pend_cout;
   logic          pend_err;

   initial begin
      MOD       = 1;
      for (int i = 0; i < D; i++) MOD = MOD * 10;
      exp_sum   = '0;
      exp_cout  = 1'b0;
      exp_err   = 1'b0;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      remaining = 0;
      finishing = 1'b0;
   end

   task automatic model_accept();
      longint av, bv, t;
      if (!bcd_ok(a_bcd) || !bcd_ok(b_bcd)) begin
         pend_err  = 1'b1;
         pend_sum  = '1;
         pend_cout = 1'b0;
      end else begin
         av = bcd2int(a_bcd);
         bv = bcd2int(b_bcd);
         pend_err = 1'b0;
         if (sub) begin
            t         = av - bv;
            pend_cout = (t >= 0);
            if (t < 0) t = t + MOD;
         end else begin
            t         = av + bv + longint'(cin);
            pend_cout = (t >= MOD);
            t         = t % MOD;
         end
         pend_sum = int2bcd(t);
      end
      remaining = D;
   endtask

   always @(posedge clk) begin
      if (!KEY0) begin
         exp_sum   = '0;
         exp_cout  = 1'b0;
         exp_err   = 1'b0;
         exp_done  = 1'b0;
         remaining = 0;
         finishing = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (finishing) begin
            exp_sum   = pend_sum;
            exp_cout  = pend_cout;
            exp_err   = pend_err;
            exp_done  = 1'b1;
            finishing = 1'b0;
            if (start) model_accept();
         end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) finishing = 1'b1;
         end else if (start) begin
            model_accept();
         end
      end
      exp_busy = (remaining > 0);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("done", 64'(done), 64'(exp_done));
         chk("sum",  64'(sum_bcd), 64'(exp_sum));
         chk("cout", 64'(cout), 64'(exp_cout));
         chk("err",  64'(err), 64'(exp_err));
      end
   end

   // ---------------- directed helpers ----------------
   int nbusy;

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic run_op(input logic s, input logic c,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit scramble);
      bit ok = 1'b0;
      sub   = s;
      cin   = c;
      a_bcd = a;
      b_bcd = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) nbusy++;
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (scramble && busy) begin
            a_bcd = rand_bcd(1'b0);
            b_bcd = rand_bcd(1'b0);
            sub   = 1'($urandom);
            cin   = 1'($urandom);
            start = 1'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      if (!ok) begin
         fails++;
         $display("FAIL done_timeout actual=0 required=1 t=%0t", $time);
      end
   endtask

   // ---------------- main sequence ----------------
   int last_done;
   int gaps;

   initial begin
      checks = 0;
      fails  = 0;
      chk_en = 1'b0;
      KEY0   = 1'b0;
      start  = 1'b0;
      sub    = 1'b0;
      cin    = 1'b0;
      a_bcd  = '0;
      b_bcd  = '0;
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      KEY0 = 1'b1;
      chk("rst_sum",  64'(sum_bcd), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      @(negedge clk);

      run_op(1'b0, 1'b0, 16'h1234, 16'h5678, 1'b0);
      chk("add1_sum",   64'(sum_bcd), 64'h6912);
      chk("add1_cout",  64'(cout), 64'h0);
      chk("add1_err",   64'(err), 64'h0);
      chk("add1_busyn", 64'(nbusy), 64'd4);
      chk("model_pin1", 64'(exp_sum), 64'h6912);

      run_op(1'b0, 1'b0, 16'h9999, 16'h0001, 1'b0);
      chk("wrap_sum",  64'(sum_bcd), 64'h0000);
      chk("wrap_cout", 64'(cout), 64'h1);

      run_op(1'b0, 1'b1, 16'h9999, 16'h9999, 1'b0);
      chk("max_sum",  64'(sum_bcd), 64'h9999);
      chk("max_cout", 64'(cout), 64'h1);

      run_op(1'b1, 1'b1, 16'h0500, 16'h0123, 1'b0);
      chk("subp_sum",  64'(sum_bcd), 64'h0377);
      chk("subp_cout", 64'(cout), 64'h1);
      chk("model_pin2", 64'(exp_sum), 64'h0377);

      run_op(1'b1, 1'b1, 16'h0123, 16'h0500, 1'b0);
      chk("subn_sum",  64'(sum_bcd), 64'h9623);
      chk("subn_cout", 64'(cout), 64'h0);
      chk("model_pin3", 64'(exp_cout), 64'h0);

      run_op(1'b0, 1'b0, 16'h12A4, 16'h0001, 1'b0);
      chk("bad_err",  64'(err), 64'h1);
      chk("bad_sum",  64'(sum_bcd), 64'hFFFF);
      chk("bad_cout", 64'(cout), 64'h0);

      run_op(1'b0, 1'b0, 16'h0042, 16'h0058, 1'b0);
      chk("clr_err", 64'(err), 64'h0);
      chk("clr_sum", 64'(sum_bcd), 64'h0100);

      // Operands and start scrambled while digits are in flight.
      run_op(1'b0, 1'b1, 16'h4321, 16'h1111, 1'b1);
      chk("scr_sum",  64'(sum_bcd), 64'h5433);
      chk("scr_cout", 64'(cout), 64'h0);
      repeat (3) @(negedge clk);

      // start held high: done every D+1 cycles.
      start     = 1'b1;
      last_done = -1;
      gaps      = 0;
      for (int i = 0; i < 40; i++) begin
         a_bcd = rand_bcd(1'b0);
         b_bcd = rand_bcd(1'b0);
         sub   = 1'($urandom);
         cin   = 1'($urandom);
         @(negedge clk);
         if (done) begin
            if (last_done >= 0) begin
               chk("held_gap", 64'(i - last_done), 64'(D + 1));
               gaps++;
            end
            last_done = i;
         end
      end
      chk("held_gaps_seen", 64'(gaps >= 5), 64'h1);
      start = 1'b0;
      repeat (8) @(negedge clk);

      // Reset on the second ADD cycle.
      sub   = 1'b0;
      cin   = 1'b0;
      a_bcd = 16'h0777;
      b_bcd = 16'h0111;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      KEY0 = 1'b0;
      @(negedge clk);
      KEY0 = 1'b1;
      chk("mrst_busy", 64'(busy), 64'h0);
      chk("mrst_done", 64'(done), 64'h0);
      chk("mrst_sum",  64'(sum_bcd), 64'h0);
      chk("mrst_cout", 64'(cout), 64'h0);
      chk("mrst_err",  64'(err), 64'h0);
      @(negedge clk);
      run_op(1'b0, 1'b0, 16'h0777, 16'h0111, 1'b0);
      chk("post_rst_sum", 64'(sum_bcd), 64'h0888);

      // Random traffic, including the odd reset.
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         sub   = 1'($urandom);
         cin   = 1'($urandom);
         a_bcd = rand_bcd(1'b1);
         b_bcd = rand_bcd(1'b1);
         KEY0  = ($urandom_range(0, 149) != 0);
      end
      @(negedge clk);
      KEY0  = 1'b1;
      start = 1'b0;
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
